// File: rtl/data_memory_mc.sv
// data_memory_mc
//   Multi-cycle, byte-addressable data memory for the MEM stage. An access is
//   accepted on Req while not busy. It completes LATENCY cycles later with a
//   one-cycle Valid pulse. Illegal accesses report Fault instead of touching
//   the array.
//
// Ports
//   clk      : clock, all state changes on the rising edge
//   rst      : synchronous active-high reset; preloads the array, aborts access
//   Req      : access request, sampled only while Busy = 0
//   WrEn     : 1 = store, 0 = load
//   ByteOp   : 1 = byte access, 0 = full-word access
//   SignExt  : byte loads only, 1 = sign-extend, 0 = zero-extend
//   Address  : byte address (word index in upper bits, lane in low LB bits)
//   DataIn   : store data (byte stores use DataIn[7:0])
//   DataOut  : registered load result, held until the next load response
//   Valid    : one-cycle response pulse
//   Busy     : access in flight, new requests ignored
//   Fault    : registered, qualifies the response as illegal
module data_memory_mc #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int DEPTH   = 32,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Req,
    input  logic              WrEn,
    input  logic              ByteOp,
    input  logic              SignExt,
    input  logic [ADDR_W-1:0] Address,
    input  logic [DATA_W-1:0] DataIn,
    output logic [DATA_W-1:0] DataOut,
    output logic              Valid,
    output logic              Busy,
    output logic              Fault
);

    localparam int LANES = DATA_W / 8;
    localparam int LB    = $clog2(LANES);
    localparam int AW    = $clog2(DEPTH);
    localparam int IW    = ADDR_W - LB;
    localparam int CW    = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------
    function automatic logic [DATA_W-1:0] preload_word(input int idx);
        logic [DATA_W-1:0] v;
        v = '0;
        case (idx)
            0:       v = DATA_W'(16'h2BCD);
            1:       v = DATA_W'(16'h0000);
            2:       v = DATA_W'(16'h1234);
            3:       v = DATA_W'(16'hDEAD);
            4:       v = DATA_W'(16'hBEEF);
            default: v = '0;
        endcase
        return v;
    endfunction

    // Replace either the whole word or just the addressed lane.
    function automatic logic [DATA_W-1:0] store_merge(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] wdata,
        input logic [LB-1:0]     lane,
        input logic              byte_op
    );
        logic [DATA_W-1:0] w;
        if (byte_op) begin
            w = old_word;
            for (int l = 0; l < LANES; l++) begin
                if (lane == LB'(l)) begin
                    w[8*l +: 8] = wdata[7:0];
                end
            end
        end else begin
            w = wdata;
        end
        return w;
    endfunction

    // Extract the addressed byte and widen it (signed widening replicates bit 7).
    function automatic logic [DATA_W-1:0] load_extract(
        input logic [DATA_W-1:0] word,
        input logic [LB-1:0]     lane,
        input logic              byte_op,
        input logic              sign_ext
    );
        logic        [7:0]        b;
        logic signed [7:0]        bs;
        logic signed [DATA_W-1:0] sx;
        logic        [DATA_W-1:0] r;
        b = '0;
        for (int l = 0; l < LANES; l++) begin
            if (lane == LB'(l)) begin
                b = word[8*l +: 8];
            end
        end
        bs = signed'(b);
        sx = bs;
        if (!byte_op) begin
            r = word;
        end else if (sign_ext) begin
            r = unsigned'(sx);
        end else begin
            r = {{(DATA_W-8){1'b0}}, b};
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem_q [DEPTH];

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              fault_q, fault_d;

    // Request fields captured at acceptance, used for the rest of the access
    logic [AW-1:0]     idx_q;
    logic [LB-1:0]     lane_q;
    logic [DATA_W-1:0] din_q;
    logic              wr_q;
    logic              bo_q;
    logic              se_q;
    logic              flt_q;

    // ------------------------------------------------------------------
    // Address decode of the live request
    // ------------------------------------------------------------------
    logic [IW-1:0] widx_live;
    logic [LB-1:0] lane_live;
    logic          range_hi;
    logic          fault_live;

    assign widx_live = Address[ADDR_W-1:LB];
    assign lane_live = Address[LB-1:0];

    // DEPTH is a power of two, so "index >= DEPTH" is any bit set above AW.
    generate
        if (IW > AW) begin : g_range
            assign range_hi = |widx_live[IW-1:AW];
        end else begin : g_norange
            assign range_hi = 1'b0;
        end
    endgenerate

    assign fault_live = range_hi | (!ByteOp && (lane_live != '0));

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    logic accept;
    logic commit;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        commit  = 1'b0;
        case (state_q)
            S_IDLE, S_RESP: begin
                if (Req) begin
                    accept = 1'b1;
                    if (LATENCY == 1) begin
                        // Single-cycle: commit straight from the live inputs
                        commit  = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CW'(LATENCY - 1);
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (cnt_q == CW'(1)) begin
                    commit  = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Commit datapath: latched fields in WAIT, live fields otherwise
    // ------------------------------------------------------------------
    logic              use_latched;
    logic [AW-1:0]     a_idx;
    logic [LB-1:0]     a_lane;
    logic [DATA_W-1:0] a_din;
    logic              a_wr;
    logic              a_bo;
    logic              a_se;
    logic              a_flt;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] wr_word_d;

    assign use_latched = (state_q == S_WAIT);
    assign a_idx  = use_latched ? idx_q  : widx_live[AW-1:0];
    assign a_lane = use_latched ? lane_q : lane_live;
    assign a_din  = use_latched ? din_q  : DataIn;
    assign a_wr   = use_latched ? wr_q   : WrEn;
    assign a_bo   = use_latched ? bo_q   : ByteOp;
    assign a_se   = use_latched ? se_q   : SignExt;
    assign a_flt  = use_latched ? flt_q  : fault_live;

    assign rd_word   = mem_q[a_idx];
    assign wr_word_d = store_merge(rd_word, a_din, a_lane, a_bo);

    always_comb begin
        dout_d  = dout_q;
        fault_d = fault_q;
        if (commit) begin
            fault_d = a_flt;
            // Faulting accesses and stores leave DataOut untouched
            if (!a_flt && !a_wr) begin
                dout_d = load_extract(rd_word, a_lane, a_bo, a_se);
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dout_q  <= '0;
            fault_q <= 1'b0;
            idx_q   <= '0;
            lane_q  <= '0;
            din_q   <= '0;
            wr_q    <= 1'b0;
            bo_q    <= 1'b0;
            se_q    <= 1'b0;
            flt_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= preload_word(i);
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            fault_q <= fault_d;
            if (accept) begin
                idx_q  <= widx_live[AW-1:0];
                lane_q <= lane_live;
                din_q  <= DataIn;
                wr_q   <= WrEn;
                bo_q   <= ByteOp;
                se_q   <= SignExt;
                flt_q  <= fault_live;
            end
            if (commit && a_wr && !a_flt) begin
                mem_q[a_idx] <= wr_word_d;
            end
        end
    end

    // Outputs are decoded from registered state only
    assign DataOut = dout_q;
    assign Fault   = fault_q;
    assign Valid   = (state_q == S_RESP);
    assign Busy    = (state_q == S_WAIT);

endmodule

// File: tb/tb_data_memory_mc.sv
module tb_data_memory_mc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        WrEn = 1'b0, ByteOp = 1'b0, SignExt = 1'b0;
    logic [15:0] Address = '0;
    logic [15:0] DataIn = '0;

    logic        Req2 = 1'b0, Req3 = 1'b0, Req1 = 1'b0;
    logic [15:0] DataOut2, DataOut3, DataOut1;
    logic        Valid2, Busy2, Fault2;
    logic        Valid3, Busy3, Fault3;
    logic        Valid1, Busy1, Fault1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    data_memory_mc #(.DATA_W(16), .ADDR_W(16), .DEPTH(32), .LATENCY(2)) u_lat2 (
        .clk(clk), .rst(rst), .Req(Req2), .WrEn(WrEn), .ByteOp(ByteOp),
        .SignExt(SignExt), .Address(Address), .DataIn(DataIn),
        .DataOut(DataOut2), .Valid(Valid2), .Busy(Busy2), .Fault(Fault2)
    );

    data_memory_mc #(.DATA_W(16), .ADDR_W(16), .DEPTH(32), .LATENCY(3)) u_lat3 (
        .clk(clk), .rst(rst), .Req(Req3), .WrEn(WrEn), .ByteOp(ByteOp),
        .SignExt(SignExt), .Address(Address), .DataIn(DataIn),
        .DataOut(DataOut3), .Valid(Valid3), .Busy(Busy3), .Fault(Fault3)
    );

    data_memory_mc #(.DATA_W(16), .ADDR_W(16), .DEPTH(32), .LATENCY(1)) u_lat1 (
        .clk(clk), .rst(rst), .Req(Req1), .WrEn(WrEn), .ByteOp(ByteOp),
        .SignExt(SignExt), .Address(Address), .DataIn(DataIn),
        .DataOut(DataOut1), .Valid(Valid1), .Busy(Busy1), .Fault(Fault1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One access on the LATENCY=2 instance with fixed-cycle handshake checks.
    task automatic acc2(input string tag, input logic wr, input logic bo, input logic se,
                        input logic [15:0] addr, input logic [15:0] din,
                        input logic [15:0] exp_dout, input logic exp_flt);
        @(negedge clk);
        WrEn = wr; ByteOp = bo; SignExt = se; Address = addr; DataIn = din;
        Req2 = 1'b1;
        @(negedge clk);
        Req2 = 1'b0;
        WrEn = 1'b0; ByteOp = 1'b0; Address = 16'h0FFF;
        check({tag, "_busy"}, {31'b0, Busy2}, 32'd1);
        check({tag, "_novalid"}, {31'b0, Valid2}, 32'd0);
        @(negedge clk);
        check({tag, "_valid"}, {31'b0, Valid2}, 32'd1);
        check({tag, "_busy_rsp"}, {31'b0, Busy2}, 32'd0);
        check({tag, "_dout"}, {16'b0, DataOut2}, {16'b0, exp_dout});
        check({tag, "_fault"}, {31'b0, Fault2}, {31'b0, exp_flt});
    endtask

    logic [15:0] vals [4];

    initial begin
        vals[0] = 16'h1357; vals[1] = 16'h2468; vals[2] = 16'h9ABC; vals[3] = 16'hF00D;

        // Reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_dout", {16'b0, DataOut2}, 32'h0);
        check("rst_valid", {31'b0, Valid2}, 32'd0);
        check("rst_busy", {31'b0, Busy2}, 32'd0);
        check("rst_fault", {31'b0, Fault2}, 32'd0);

        // Preloaded contents
        acc2("ld0", 1'b0, 1'b0, 1'b0, 16'd0, 16'h0, 16'h2BCD, 1'b0);
        acc2("ld2", 1'b0, 1'b0, 1'b0, 16'd2, 16'h0, 16'h0000, 1'b0);
        acc2("ld4", 1'b0, 1'b0, 1'b0, 16'd4, 16'h0, 16'h1234, 1'b0);
        acc2("ld6", 1'b0, 1'b0, 1'b0, 16'd6, 16'h0, 16'hDEAD, 1'b0);
        acc2("ld8", 1'b0, 1'b0, 1'b0, 16'd8, 16'h0, 16'hBEEF, 1'b0);
        @(negedge clk);
        check("valid_oneshot", {31'b0, Valid2}, 32'd0);

        // Byte lanes: store leaves DataOut alone
        acc2("sb7", 1'b1, 1'b1, 1'b0, 16'd7, 16'h33A5, 16'hBEEF, 1'b0);
        acc2("lw6", 1'b0, 1'b0, 1'b0, 16'd6, 16'h0, 16'hA5AD, 1'b0);
        acc2("lb7s", 1'b0, 1'b1, 1'b1, 16'd7, 16'h0, 16'hFFA5, 1'b0);
        acc2("lb7z", 1'b0, 1'b1, 1'b0, 16'd7, 16'h0, 16'h00A5, 1'b0);
        acc2("lb6s", 1'b0, 1'b1, 1'b1, 16'd6, 16'h0, 16'hFFAD, 1'b0);
        acc2("sb4", 1'b1, 1'b1, 1'b0, 16'd4, 16'hFF77, 16'hFFAD, 1'b0);
        acc2("lw4", 1'b0, 1'b0, 1'b0, 16'd4, 16'h0, 16'h1277, 1'b0);

        // Faults: misaligned word load, out-of-range store, then recovery
        acc2("lw3", 1'b0, 1'b0, 1'b0, 16'd3, 16'h0, 16'h1277, 1'b1);
        acc2("sw64", 1'b1, 1'b0, 1'b0, 16'd64, 16'h5555, 16'h1277, 1'b1);
        acc2("lw0", 1'b0, 1'b0, 1'b0, 16'd0, 16'h0, 16'h2BCD, 1'b0);
        acc2("sw10", 1'b1, 1'b0, 1'b0, 16'd10, 16'hCAFE, 16'h2BCD, 1'b0);
        acc2("lw10", 1'b0, 1'b0, 1'b0, 16'd10, 16'h0, 16'hCAFE, 1'b0);

        // LATENCY=3 with Req held high: Valid every third cycle
        @(negedge clk);
        WrEn = 1'b0; ByteOp = 1'b0; SignExt = 1'b0; Address = 16'd4;
        Req3 = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check($sformatf("l3_hold_v%0d", k), {31'b0, Valid3}, {31'b0, (k % 3) == 2});
        end
        Req3 = 1'b0;
        check("l3_hold_dout", {16'b0, DataOut3}, 32'h1234);
        @(negedge clk);
        check("l3_idle_v", {31'b0, Valid3}, 32'd0);
        check("l3_idle_b", {31'b0, Busy3}, 32'd0);

        // Req kept high through the busy cycles: only one response
        Req3 = 1'b1;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            check($sformatf("l3_ign_v%0d", k), {31'b0, Valid3}, {31'b0, k == 2});
            check($sformatf("l3_ign_b%0d", k), {31'b0, Busy3}, {31'b0, k < 2});
            if (k == 2) Req3 = 1'b0;
        end

        // LATENCY=1: alternating store/load to word 6
        Address = 16'd12; ByteOp = 1'b0; SignExt = 1'b0;
        Req1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i > 0) begin
                check($sformatf("l1_ld_v%0d", i), {31'b0, Valid1}, 32'd1);
                check($sformatf("l1_ld_d%0d", i), {16'b0, DataOut1}, {16'b0, vals[i-1]});
            end
            check($sformatf("l1_busy_a%0d", i), {31'b0, Busy1}, 32'd0);
            WrEn = 1'b1; DataIn = vals[i];
            @(negedge clk);
            check($sformatf("l1_st_v%0d", i), {31'b0, Valid1}, 32'd1);
            check($sformatf("l1_busy_b%0d", i), {31'b0, Busy1}, 32'd0);
            WrEn = 1'b0; DataIn = 16'h0;
        end
        @(negedge clk);
        Req1 = 1'b0;
        check("l1_ld_d4", {16'b0, DataOut1}, {16'b0, vals[3]});

        // Reset during WAIT aborts the store
        @(negedge clk);
        WrEn = 1'b1; ByteOp = 1'b0; Address = 16'd2; DataIn = 16'h1111;
        Req2 = 1'b1;
        @(negedge clk);
        Req2 = 1'b0;
        check("abort_busy", {31'b0, Busy2}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_valid", {31'b0, Valid2}, 32'd0);
        check("abort_busy0", {31'b0, Busy2}, 32'd0);
        @(negedge clk);
        check("abort_valid2", {31'b0, Valid2}, 32'd0);
        acc2("rld2", 1'b0, 1'b0, 1'b0, 16'd2, 16'h0, 16'h0000, 1'b0);
        acc2("rld4", 1'b0, 1'b0, 1'b0, 16'd4, 16'h0, 16'h1234, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
